reg_dump: RTL and testbench
===========================

# reg_dump

Sequential read-side companion to `reg_file`: on a `start` pulse it walks a contiguous, wrapping range of register addresses and streams each 8-bit value out over a valid/ready handshake. It fetches two registers per read cycle, using `reg_file` read ports A and B together, and buffers the pair internally. It sits between `reg_file` and debug or trace logic, alongside the normal datapath readers.

## Interface
- `DW`, 8, register data width
- `AW`, 3, register address width (2^AW registers)

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a dump; sampled only in IDLE
- `start_addr`  in  AW  first register address
- `count`  in  AW+1  number of registers to dump; 0 = none; values > 2^AW clamp to 2^AW
- `raddrA`  out  AW  to `reg_file` `raddrA`
- `raddrB`  out  AW  to `reg_file` `raddrB`
- `data_outA`  in  DW  from `reg_file` `data_outA`; combinational read
- `data_outB`  in  DW  from `reg_file` `data_outB`; combinational read
- `dout`  out  DW  streamed register value
- `dout_addr`  out  AW  address of the value on `dout`
- `dout_par`  out  1  even parity of `dout` (see Configuration)
- `dout_valid`  out  1  `dout` is valid
- `dout_ready`  in  1  consumer accepts the beat
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the dump completes

## Operation
- **State machine:** IDLE, FETCH, SEND_A, SEND_B, DONE.
- **IDLE:**
  - On `start`, latch `ptr = start_addr` and `rem = clamp(count)`.
  - If `rem == 0`, go to DONE; otherwise go to FETCH.
- **FETCH (exactly one cycle):**
  - Drive `raddrA = ptr` and `raddrB = ptr+1` (mod 2^AW).
  - Capture `data_outA` into `bufA` and `data_outB` into `bufB` at the clock edge.
  - Go to SEND_A.
- **SEND_A:**
  - `dout = bufA`, `dout_addr = ptr`, `dout_valid = 1`.
  - On `dout_ready`: `rem--`. If `rem` becomes 0, go to DONE; otherwise go to SEND_B.
- **SEND_B:**
  - `dout = bufB`, `dout_addr = ptr+1`, `dout_valid = 1`.
  - On `dout_ready`: `rem--` and `ptr += 2` (wraps mod 2^AW). If `rem` becomes 0, go to DONE; otherwise go to FETCH.
- **DONE:** `done = 1` for one cycle, then go to IDLE.
- **Address arithmetic:** modulo 2^AW. A dump starting at 7 with count 3 emits addresses 7, 0, 1.
- **Buffered values:** taken at the FETCH edge. A `reg_file` write to an already-fetched address after that edge is not reflected. A write landing on the same edge as FETCH follows `reg_file` read-during-write behaviour, which is old data.
- **Stall and ordering:** while `dout_valid` is high and `dout_ready` is low, `dout`, `dout_addr` and `dout_par` hold stable. Beats are never dropped or reordered.
- **`start` while busy:** ignored.
- **`raddrA`/`raddrB` outside FETCH:** hold their last value. Reset value is 0.

## Timing
- **Reset values:** state IDLE, `raddrA`/`raddrB` 0, `dout` 0, `dout_addr` 0, `dout_par` 0, `dout_valid` 0, `busy` 0, `done` 0.
- **Start latency:** `start` high at edge N puts the block in FETCH during cycle N+1. The first `dout_valid` is in cycle N+2.
- **Throughput with `dout_ready` held high:** 2 beats per 3 cycles (FETCH, SEND_A, SEND_B).
- **Completion:** `done` is asserted in the cycle after the final accepted beat. `busy` drops in the cycle after `done`.
- **Zero count:** `start` with `count = 0` gives IDLE → DONE → IDLE. `done` is high in cycle N+1 and no beat is issued.
- **Reset mid-dump:** takes effect at the next edge. Go to IDLE, deassert `dout_valid`, discard remaining beats, no `done` pulse.
- **Back-to-back dumps:** `start` in the cycle IDLE is re-entered begins a new dump.

## Configuration
- **`REG_DUMP_PARITY_EN` defined:**
  - `dout_par` = XOR-reduce of `dout`, registered alongside `dout`.
  - Parity is computed from the buffered value.
- **`REG_DUMP_PARITY_EN` not defined:**
  - `dout_par` is tied to 0.
  - No parity logic is present.
- **Unaffected by the macro:** port list and all other behaviour.

## Test plan
- **Basic dump:** preload reg2 = 0xFF, reg3 = 0xCD. `start_addr = 2`, `count = 2`, `dout_ready = 1`.
  - Expect beats (2, 0xFF) then (3, 0xCD).
  - Expect `done` one cycle after the second beat.
  - Expect first valid at N+2.
- **Wrap:** preload reg7 = 0x07, reg0 = 0x10, reg1 = 0x01. `start_addr = 7`, `count = 3`.
  - Expect addresses 7, 0, 1 with those values.
  - Expect `raddrB = 0` during the first FETCH.
- **Backpressure:** full dump `start_addr = 0`, `count = 8`, with `dout_ready` toggled 1/0 per cycle.
  - Expect 8 beats in order with `dout` stable while stalled.
  - Expect `done` after beat 7.
- **Zero and clamp:**
  - `count = 0`: `done` at N+1, `dout_valid` never high.
  - `count = 15`: exactly 8 beats.
- **Reset mid-dump:** assert `reset` for one cycle during SEND_B of a `count = 8` dump.
  - Expect `dout_valid = 0`, `busy = 0` next cycle, no `done`.
  - Expect a subsequent `start` to run normally.
- **Parity and write-after-fetch:**
  - With `REG_DUMP_PARITY_EN` defined, value 0x07 gives `dout_par = 1` and 0xFF gives 0.
  - Write reg3 = 0xAA during SEND_A of pair (2,3); expect the old reg3 value to be streamed.

Source files
------------

// File: rtl/reg_dump.sv
// Streams a wrapping range of reg_file registers out over valid/ready, two registers per read cycle.
// Optional even parity on dout is enabled by defining REG_DUMP_PARITY_EN.
module reg_dump #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] raddrA,
  output logic [AW-1:0] raddrB,
  input  logic [DW-1:0] data_outA,
  input  logic [DW-1:0] data_outB,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] dout_addr,
  output logic          dout_par,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [AW:0] MAX_CNT = (AW+1)'(2 ** AW);

  function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [AW:0]   rem, rem_n;
  logic [DW-1:0] buf_a, buf_b;
  logic [AW-1:0] ra, rb;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    rem_n   = rem;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_n   = start_addr;
          rem_n   = clamp_count(count);
          state_n = (rem_n == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_n = SEND_A;
      SEND_A: begin
        if (dout_ready) begin
          rem_n   = rem - (AW+1)'(1);
          state_n = (rem_n == '0) ? DONE : SEND_B;
        end
      end
      SEND_B: begin
        if (dout_ready) begin
          rem_n   = rem - (AW+1)'(1);
          ptr_n   = ptr + AW'(2);
          state_n = (rem_n == '0) ? DONE : FETCH;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read addresses are registered and loaded on entry to FETCH, so they hold outside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      buf_a <= '0;
      buf_b <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
      if (state == FETCH) begin
        buf_a <= data_outA;
        buf_b <= data_outB;
      end
      if (state_n == FETCH) begin
        ra <= ptr_n;
        rb <= ptr_n + AW'(1);
      end
    end
  end

`ifdef REG_DUMP_PARITY_EN
  function automatic logic even_parity(input logic [DW-1:0] d);
    return ^d;
  endfunction

  logic par_a, par_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_a <= 1'b0;
      par_b <= 1'b0;
    end else if (state == FETCH) begin
      par_a <= even_parity(data_outA);
      par_b <= even_parity(data_outB);
    end
  end

  assign dout_par = (state == SEND_B) ? par_b : par_a;
`else
  assign dout_par = 1'b0;
`endif

  assign raddrA     = ra;
  assign raddrB     = rb;
  assign dout       = (state == SEND_B) ? buf_b : buf_a;
  assign dout_addr  = (state == SEND_B) ? ptr + AW'(1) : ptr;
  assign dout_valid = (state == SEND_A) || (state == SEND_B);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump with a behavioural combinational-read register file.
module tb_reg_dump;
  localparam int DW = 8;
  localparam int AW = 3;

`ifdef REG_DUMP_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   count;
  logic [AW-1:0] raddrA, raddrB;
  logic [DW-1:0] data_outA, data_outB;
  logic [DW-1:0] dout;
  logic [AW-1:0] dout_addr;
  logic          dout_par, dout_valid, dout_ready, busy, done;

  logic [DW-1:0] regs [8];
  assign data_outA = regs[raddrA];
  assign data_outB = regs[raddrB];

  reg_dump #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
    .raddrA(raddrA), .raddrB(raddrB), .data_outA(data_outA), .data_outB(data_outB),
    .dout(dout), .dout_addr(dout_addr), .dout_par(dout_par), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Preloaded register contents and their hand-computed even parities.
  logic [DW-1:0] exp_val [8] = '{8'h10, 8'h01, 8'hFF, 8'hCD, 8'h44, 8'h5A, 8'h3C, 8'h07};
  bit            exp_par [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  int nvec = 0;
  int nfail = 0;

  logic [AW-1:0] b_addr [$];
  logic [DW-1:0] b_data [$];
  logic          b_par  [$];
  int done_cyc, first_valid, last_beat, valid_cycles, stall_bad;
  logic [AW-1:0] fetch_ra, fetch_rb;

  task automatic issue(input logic [AW-1:0] a, input logic [AW:0] c);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records beats from cycle N+1 onward until done or the cycle budget runs out.
  task automatic collect(input int mode, input int limit);
    logic pv, pp;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    int cyc;
    b_addr.delete(); b_data.delete(); b_par.delete();
    done_cyc = -1; first_valid = -1; last_beat = -1; valid_cycles = 0; stall_bad = 0;
    pv = 1'b0; pp = 1'b0; pd = '0; pa = '0;
    cyc = 1;
    while (cyc <= limit) begin
      dout_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      @(negedge clk);
      if (cyc == 1) begin fetch_ra = raddrA; fetch_rb = raddrB; end
      if (pv && !(dout_valid && dout == pd && dout_addr == pa && dout_par == pp)) stall_bad++;
      if (dout_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        if (dout_ready) begin
          b_addr.push_back(dout_addr); b_data.push_back(dout); b_par.push_back(dout_par);
          last_beat = cyc;
        end
      end
      pv = dout_valid && !dout_ready; pd = dout; pa = dout_addr; pp = dout_par;
      if (done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({raddrA, raddrB, dout, dout_addr, dout_par, dout_valid, busy, done} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got ra=%0h rb=%0h dout=%0h addr=%0h par=%0b vld=%0b busy=%0b done=%0b expected all 0",
               raddrA, raddrB, dout, dout_addr, dout_par, dout_valid, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_basic();
    issue(3'd2, 4'd2);
    collect(0, 50);
    nvec++;
    if (fetch_ra !== 3'd2 || fetch_rb !== 3'd3) begin
      nfail++; $display("FAIL basic_raddr: got A=%0d B=%0d expected A=2 B=3", fetch_ra, fetch_rb);
    end
    nvec++;
    if (b_addr.size() !== 2) begin
      nfail++; $display("FAIL basic_beats: got %0d expected 2", b_addr.size());
    end else begin
      nvec++;
      if (b_addr[0] !== 3'd2 || b_data[0] !== 8'hFF || b_par[0] !== 1'b0) begin
        nfail++; $display("FAIL basic_beat0: got (%0d,%0h,%0b) expected (2,ff,0)", b_addr[0], b_data[0], b_par[0]);
      end
      nvec++;
      if (b_addr[1] !== 3'd3 || b_data[1] !== 8'hCD || b_par[1] !== PAR_ON) begin
        nfail++; $display("FAIL basic_beat1: got (%0d,%0h,%0b) expected (3,cd,%0b)", b_addr[1], b_data[1], b_par[1], PAR_ON);
      end
    end
    nvec++;
    if (first_valid !== 2) begin nfail++; $display("FAIL basic_first_valid: got %0d expected 2", first_valid); end
    nvec++;
    if (done_cyc !== 4 || last_beat !== 3) begin
      nfail++; $display("FAIL basic_done: got done=%0d last=%0d expected done=4 last=3", done_cyc, last_beat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin nfail++; $display("FAIL basic_busy_after_done: got %0b expected 0", busy); end
  endtask

  task automatic test_wrap();
    issue(3'd7, 4'd3);
    collect(0, 50);
    nvec++;
    if (fetch_ra !== 3'd7 || fetch_rb !== 3'd0) begin
      nfail++; $display("FAIL wrap_raddr: got A=%0d B=%0d expected A=7 B=0", fetch_ra, fetch_rb);
    end
    nvec++;
    if (b_addr.size() !== 3) begin
      nfail++; $display("FAIL wrap_beats: got %0d expected 3", b_addr.size());
    end else begin
      nvec++;
      if (b_addr[0] !== 3'd7 || b_data[0] !== 8'h07 || b_par[0] !== PAR_ON) begin
        nfail++; $display("FAIL wrap_beat0: got (%0d,%0h,%0b) expected (7,07,%0b)", b_addr[0], b_data[0], b_par[0], PAR_ON);
      end
      nvec++;
      if (b_addr[1] !== 3'd0 || b_data[1] !== 8'h10) begin
        nfail++; $display("FAIL wrap_beat1: got (%0d,%0h) expected (0,10)", b_addr[1], b_data[1]);
      end
      nvec++;
      if (b_addr[2] !== 3'd1 || b_data[2] !== 8'h01) begin
        nfail++; $display("FAIL wrap_beat2: got (%0d,%0h) expected (1,01)", b_addr[2], b_data[2]);
      end
    end
    nvec++;
    if (done_cyc !== 6) begin nfail++; $display("FAIL wrap_done: got %0d expected 6", done_cyc); end
  endtask

  task automatic test_backpressure();
    issue(3'd0, 4'd8);
    collect(1, 200);
    nvec++;
    if (b_addr.size() !== 8) begin
      nfail++; $display("FAIL bp_beats: got %0d expected 8", b_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        nvec++;
        if (b_addr[i] !== 3'(i) || b_data[i] !== exp_val[i] || b_par[i] !== (PAR_ON & exp_par[i])) begin
          nfail++;
          $display("FAIL bp_beat%0d: got (%0d,%0h,%0b) expected (%0d,%0h,%0b)", i, b_addr[i], b_data[i], b_par[i],
                   i, exp_val[i], PAR_ON & exp_par[i]);
        end
      end
    end
    nvec++;
    if (stall_bad !== 0) begin nfail++; $display("FAIL bp_stall_stable: got %0d unstable cycles expected 0", stall_bad); end
    nvec++;
    if (done_cyc < 0 || done_cyc !== last_beat + 1) begin
      nfail++; $display("FAIL bp_done: got done=%0d last=%0d expected done=last+1", done_cyc, last_beat);
    end
  endtask

  task automatic test_zero_clamp();
    issue(3'd3, 4'd0);
    collect(0, 20);
    nvec++;
    if (done_cyc !== 1 || valid_cycles !== 0) begin
      nfail++; $display("FAIL zero_count: got done=%0d valid_cycles=%0d expected done=1 valid_cycles=0", done_cyc, valid_cycles);
    end
    issue(3'd4, 4'd15);
    collect(0, 100);
    nvec++;
    if (b_addr.size() !== 8) begin
      nfail++; $display("FAIL clamp_beats: got %0d expected 8", b_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        nvec++;
        if (b_addr[i] !== 3'((i + 4) % 8) || b_data[i] !== exp_val[(i + 4) % 8]) begin
          nfail++;
          $display("FAIL clamp_beat%0d: got (%0d,%0h) expected (%0d,%0h)", i, b_addr[i], b_data[i], (i + 4) % 8,
                   exp_val[(i + 4) % 8]);
        end
      end
    end
    nvec++;
    if (done_cyc !== 13) begin nfail++; $display("FAIL clamp_done: got %0d expected 13", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    issue(3'd0, 4'd8);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (dout_valid !== 1'b1 || dout_addr !== 3'd1) begin
      nfail++; $display("FAIL rst_mid_sendb: got vld=%0b addr=%0d expected vld=1 addr=1", dout_valid, dout_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nfail++; $display("FAIL rst_mid_after: got vld=%0b busy=%0b done=%0b expected 0 0 0", dout_valid, busy, done);
    end
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    nvec++;
    if (seen_done !== 0) begin nfail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen_done); end
    issue(3'd6, 4'd2);
    collect(0, 50);
    nvec++;
    if (b_addr.size() !== 2 || done_cyc !== 4) begin
      nfail++; $display("FAIL rst_mid_restart: got beats=%0d done=%0d expected beats=2 done=4", b_addr.size(), done_cyc);
    end else begin
      nvec++;
      if (b_addr[0] !== 3'd6 || b_data[0] !== 8'h3C || b_addr[1] !== 3'd7 || b_data[1] !== 8'h07) begin
        nfail++; $display("FAIL rst_mid_restart_data: got (%0d,%0h)(%0d,%0h) expected (6,3c)(7,07)",
                          b_addr[0], b_data[0], b_addr[1], b_data[1]);
      end
    end
  endtask

  task automatic test_write_after_fetch();
    issue(3'd2, 4'd2);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    regs[3] = 8'hAA;
    @(negedge clk);
    nvec++;
    if (dout_valid !== 1'b1 || dout_addr !== 3'd2 || dout !== 8'hFF || dout_par !== 1'b0) begin
      nfail++; $display("FAIL waf_beat_a: got (%0b,%0d,%0h,%0b) expected (1,2,ff,0)", dout_valid, dout_addr, dout, dout_par);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (dout_valid !== 1'b1 || dout_addr !== 3'd3 || dout !== 8'hCD || dout_par !== PAR_ON) begin
      nfail++; $display("FAIL waf_beat_b: got (%0b,%0d,%0h,%0b) expected (1,3,cd,%0b)", dout_valid, dout_addr, dout, dout_par, PAR_ON);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (done !== 1'b1) begin nfail++; $display("FAIL waf_done: got %0b expected 1", done); end
    regs[3] = 8'hCD;
  endtask

  task automatic test_back_to_back();
    issue(3'd5, 4'd1);
    start = 1'b1; start_addr = 3'd0; count = 4'd8;
    collect(0, 30);
    nvec++;
    if (b_addr.size() !== 1 || done_cyc !== 3) begin
      nfail++; $display("FAIL b2b_first: got beats=%0d done=%0d expected beats=1 done=3", b_addr.size(), done_cyc);
    end else begin
      nvec++;
      if (b_addr[0] !== 3'd5 || b_data[0] !== 8'h5A) begin
        nfail++; $display("FAIL b2b_first_data: got (%0d,%0h) expected (5,5a)", b_addr[0], b_data[0]);
      end
    end
    issue(3'd6, 4'd1);
    collect(0, 30);
    nvec++;
    if (b_addr.size() !== 1 || first_valid !== 2 || done_cyc !== 3) begin
      nfail++; $display("FAIL b2b_second: got beats=%0d first=%0d done=%0d expected 1 2 3", b_addr.size(), first_valid, done_cyc);
    end else begin
      nvec++;
      if (b_addr[0] !== 3'd6 || b_data[0] !== 8'h3C) begin
        nfail++; $display("FAIL b2b_second_data: got (%0d,%0h) expected (6,3c)", b_addr[0], b_data[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = exp_val[i];
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_clamp();
    test_reset_mid();
    test_write_after_fetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
